ascon_perm_ctrl: RTL and testbench

- Sequencing controller for the ASCON permutation p^a, with a = 12 or 6.
- Holds the 320-bit state register and drives an external combinational round datapath (constant addition, substitution layer, linear layer) one round per cycle.
- Supplies the round datapath with a and the round index i; the constant stage resolves these to constant index 12 - a + i.
- Sits between the AEAD/hash mode FSM (requester) and the round datapath.

---
 rtl/ascon_perm_ctrl_if.sv | 24 ++
 rtl/ascon_perm_ctrl.sv | 94 +++++++++
 tb/tb_ascon_perm_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_perm_ctrl_if.sv
// Requester-side handshake between the AEAD/hash mode FSM and the ASCON permutation controller.
// The mode FSM drives through the master modport; the controller receives through slave.
interface ascon_perm_ctrl_if #(
    parameter int STATE_W = 320
);
    logic               start;
    logic [3:0]         rounds;
    logic               abort;
    logic [STATE_W-1:0] state_in;
    logic               ready;
    logic               busy;
    logic               done;
    logic [STATE_W-1:0] state_out;

    modport master (
        output start, rounds, abort, state_in,
        input  ready, busy, done, state_out
    );

    modport slave (
        input  start, rounds, abort, state_in,
        output ready, busy, done, state_out
    );
endinterface

// File: rtl/ascon_perm_ctrl.sv
// ASCON p^a sequencer: owns the 320-bit state and steps an external
// combinational round datapath one round per clock.
module ascon_perm_ctrl #(
    parameter int STATE_W = 320
) (
    input  logic               clk,
    input  logic               rst,
    ascon_perm_ctrl_if.slave   req,
    output logic [3:0]         round_a,
    output logic [3:0]         round_i,
    output logic [STATE_W-1:0] round_state,
    input  logic [STATE_W-1:0] round_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t               fsm_q;
    fsm_t               fsm_d;
    logic [STATE_W-1:0] state_reg;
    logic [3:0]         a_reg;
    logic [3:0]         i_reg;
    logic               done_q;
    logic               accept;
    logic               last_round;

    assign last_round = (i_reg == (a_reg - 4'd1));

    always_comb begin
        fsm_d  = fsm_q;
        accept = 1'b0;
        case (fsm_q)
            IDLE, DONE: begin
                if (req.start) begin
                    accept = 1'b1;
                    fsm_d  = RUN;
                end
            end
            RUN: begin
                // abort outranks completion, so a cancelled last round never pulses done
                if (req.abort) begin
                    fsm_d = IDLE;
                end else if (last_round) begin
                    fsm_d = DONE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q  <= IDLE;
            done_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            done_q <= (fsm_q == RUN) && (fsm_d == DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= '0;
            a_reg     <= 4'd12;
            i_reg     <= 4'd0;
        end else if (accept) begin
            state_reg <= req.state_in;
            a_reg     <= (req.rounds == 4'd6) ? 4'd6 : 4'd12;
            i_reg     <= 4'd0;
        end else if (fsm_q == RUN) begin
            if (req.abort) begin
                i_reg <= 4'd0;
            end else begin
                state_reg <= round_result;
                // index parks on the last round so 12 - a + i stays within 0..11
                if (!last_round) begin
                    i_reg <= i_reg + 4'd1;
                end
            end
        end
    end

    assign req.ready     = (fsm_q != RUN);
    assign req.busy      = (fsm_q == RUN);
    assign req.done      = done_q;
    assign req.state_out = state_reg;
    assign round_state   = state_reg;
    assign round_a       = a_reg;
    assign round_i       = i_reg;

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Bench for ascon_perm_ctrl with a behavioural ASCON round datapath attached.
module tb_ascon_perm_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   round_a;
    logic [3:0]   round_i;
    logic [319:0] round_state;
    logic [319:0] round_result;

    int tests = 0;
    int fails = 0;

    localparam logic [319:0] KAT_IN = {64'h80400c0600000000,
                                       128'h000102030405060708090a0b0c0d0e0f,
                                       128'h000102030405060708090a0b0c0d0e0f};
    localparam logic [319:0] S1 = {5{64'h0123456789abcdef}};
    localparam logic [319:0] S2 = {5{64'hfedcba9876543210}};
    localparam logic [319:0] S3 = {64'h1, 64'h2, 64'h3, 64'h4, 64'h5};
    localparam logic [319:0] S4 = {5{64'hdeadbeefcafef00d}};
    localparam logic [319:0] S5 = {5{64'h5555aaaa3333cccc}};

    ascon_perm_ctrl_if bus ();

    ascon_perm_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req          (bus),
        .round_a      (round_a),
        .round_i      (round_i),
        .round_state  (round_state),
        .round_result (round_result)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] ascon_round(input logic [319:0] s, input int k);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        logic [7:0]  rc;
        x0 = s[319:256]; x1 = s[255:192]; x2 = s[191:128]; x3 = s[127:64]; x4 = s[63:0];
        rc = {4'(15 - k), 4'(k)};
        x2 = x2 ^ {56'd0, rc};
        x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
        x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    // Reference: first n rounds of p^a applied to s
    function automatic logic [319:0] perm_n(input logic [319:0] s, input int a, input int n);
        logic [319:0] r;
        r = s;
        for (int j = 0; j < n; j++) r = ascon_round(r, 12 - a + j);
        return r;
    endfunction

    always_comb round_result = ascon_round(round_state, 12 - int'(round_a) + int'(round_i));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_perm(input logic [319:0] s, input logic [3:0] r);
        bus.state_in = s;
        bus.rounds   = r;
        bus.start    = 1'b1;
        step();
        bus.start    = 1'b0;
    endtask

    // Walks cycles from first_cyc until done, gathering timing observations
    task automatic run_observe(input logic [3:0] exp_a, input int first_cyc,
                               output int done_cyc, output int busy_cnt,
                               output int idx_err, output int a_err);
        done_cyc = -1;
        busy_cnt = first_cyc - 1;
        idx_err  = 0;
        a_err    = 0;
        for (int c = first_cyc; c <= 40; c++) begin
            if (bus.done === 1'b1) begin
                done_cyc = c;
                break;
            end
            if (bus.busy === 1'b1) begin
                busy_cnt++;
                if (round_i !== 4'(busy_cnt - 1)) idx_err++;
            end
            if (round_a !== exp_a) a_err++;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.rounds = 4'd12; bus.state_in = '0;
        step(); step();
        rst = 1'b0;
        step();
        tests++; if (bus.ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", bus.ready); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", bus.done); end
        tests++; if (bus.state_out !== 320'd0) begin fails++; $display("FAIL reset_state got %h want 0", bus.state_out); end
        tests++; if (round_i !== 4'd0) begin fails++; $display("FAIL reset_round_i got %0d want 0", round_i); end
        tests++; if (round_a !== 4'd12) begin fails++; $display("FAIL reset_round_a got %0d want 12", round_a); end
    endtask

    task automatic test_p12_kat();
        int dc, bc, ie, ae;
        logic [319:0] exp;
        exp = perm_n(KAT_IN, 12, 12);
        start_perm(KAT_IN, 4'd12);
        run_observe(4'd12, 1, dc, bc, ie, ae);
        tests++; if (dc !== 13) begin fails++; $display("FAIL p12_done_cycle got %0d want 13", dc); end
        tests++; if (bc !== 12) begin fails++; $display("FAIL p12_busy_cycles got %0d want 12", bc); end
        tests++; if (ie !== 0) begin fails++; $display("FAIL p12_round_i_seq got %0d errors want 0", ie); end
        tests++; if (bus.state_out !== exp) begin fails++; $display("FAIL p12_result got %h want %h", bus.state_out, exp); end
        step();
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL p12_done_single got %b want 0", bus.done); end
        tests++; if (bus.ready !== 1'b1) begin fails++; $display("FAIL p12_ready_after got %b want 1", bus.ready); end
        tests++; if (bus.state_out !== exp) begin fails++; $display("FAIL p12_result_held got %h want %h", bus.state_out, exp); end
    endtask

    task automatic test_p6();
        int dc, bc, ie, ae;
        logic [319:0] exp;
        exp = perm_n(320'd0, 6, 6);
        start_perm(320'd0, 4'd6);
        run_observe(4'd6, 1, dc, bc, ie, ae);
        tests++; if (dc !== 7) begin fails++; $display("FAIL p6_done_cycle got %0d want 7", dc); end
        tests++; if (bc !== 6) begin fails++; $display("FAIL p6_busy_cycles got %0d want 6", bc); end
        tests++; if (ie !== 0) begin fails++; $display("FAIL p6_round_i_seq got %0d errors want 0", ie); end
        tests++; if (ae !== 0) begin fails++; $display("FAIL p6_round_a got %0d errors want 0", ae); end
        tests++; if (bus.state_out !== exp) begin fails++; $display("FAIL p6_result got %h want %h", bus.state_out, exp); end
        step();
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL p6_done_single got %b want 0", bus.done); end
    endtask

    task automatic test_invalid_count();
        int dc, bc, ie, ae;
        logic [319:0] exp;
        exp = perm_n(S5, 12, 12);
        start_perm(S5, 4'd4);
        run_observe(4'd12, 1, dc, bc, ie, ae);
        tests++; if (ae !== 0) begin fails++; $display("FAIL inv_round_a got %0d errors want 0", ae); end
        tests++; if (dc !== 13) begin fails++; $display("FAIL inv_done_cycle got %0d want 13", dc); end
        tests++; if (bus.state_out !== exp) begin fails++; $display("FAIL inv_result got %h want %h", bus.state_out, exp); end
        step();
    endtask

    task automatic test_start_during_run();
        int dc, bc, ie, ae;
        logic [319:0] exp;
        exp = perm_n(S1, 12, 12);
        start_perm(S1, 4'd12);
        step(); step(); step();
        tests++; if (round_i !== 4'd3) begin fails++; $display("FAIL sdr_round_i got %0d want 3", round_i); end
        bus.state_in = S2;
        bus.rounds   = 4'd6;
        bus.start    = 1'b1;
        step();
        bus.start    = 1'b0;
        run_observe(4'd12, 5, dc, bc, ie, ae);
        tests++; if (dc !== 13) begin fails++; $display("FAIL sdr_done_cycle got %0d want 13", dc); end
        tests++; if (ie !== 0 || ae !== 0) begin fails++; $display("FAIL sdr_index got %0d/%0d errors want 0/0", ie, ae); end
        tests++; if (bus.state_out !== exp) begin fails++; $display("FAIL sdr_result got %h want %h", bus.state_out, exp); end
        step();
    endtask

    task automatic test_back_to_back();
        int dc, bc, ie, ae;
        logic [319:0] exp6, exp12;
        exp6  = perm_n(S2, 6, 6);
        exp12 = perm_n(S3, 12, 12);
        start_perm(S2, 4'd6);
        run_observe(4'd6, 1, dc, bc, ie, ae);
        tests++; if (dc !== 7) begin fails++; $display("FAIL b2b_first_done got %0d want 7", dc); end
        tests++; if (bus.state_out !== exp6) begin fails++; $display("FAIL b2b_first_result got %h want %h", bus.state_out, exp6); end
        start_perm(S3, 4'd12);
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL b2b_restart_busy got %b want 1", bus.busy); end
        tests++; if (round_i !== 4'd0) begin fails++; $display("FAIL b2b_restart_round_i got %0d want 0", round_i); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL b2b_restart_done got %b want 0", bus.done); end
        run_observe(4'd12, 1, dc, bc, ie, ae);
        tests++; if (dc !== 13) begin fails++; $display("FAIL b2b_second_done got %0d want 13", dc); end
        tests++; if (bus.state_out !== exp12) begin fails++; $display("FAIL b2b_second_result got %h want %h", bus.state_out, exp12); end
        step();
    endtask

    task automatic test_abort();
        int dc, bc, ie, ae, done_seen;
        logic [319:0] part, exp;
        part = perm_n(S3, 12, 5);
        exp  = perm_n(S4, 12, 12);
        start_perm(S3, 4'd12);
        repeat (5) step();
        tests++; if (round_i !== 4'd5) begin fails++; $display("FAIL abort_pre_round_i got %0d want 5", round_i); end
        bus.abort    = 1'b1;
        bus.start    = 1'b1;
        bus.state_in = S1;
        step();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        tests++; if (bus.ready !== 1'b1 || bus.busy !== 1'b0) begin fails++; $display("FAIL abort_idle got ready=%b busy=%b want 1/0", bus.ready, bus.busy); end
        tests++; if (round_i !== 4'd0) begin fails++; $display("FAIL abort_round_i got %0d want 0", round_i); end
        tests++; if (bus.state_out !== part) begin fails++; $display("FAIL abort_state got %h want %h", bus.state_out, part); end
        done_seen = 0;
        for (int c = 0; c < 15; c++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
            step();
        end
        tests++; if (done_seen !== 0) begin fails++; $display("FAIL abort_no_done got %0d active cycles want 0", done_seen); end
        // abort asserted outside RUN together with start: start must win
        bus.abort = 1'b1;
        start_perm(S4, 4'd12);
        bus.abort = 1'b0;
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL abort_idle_start got busy=%b want 1", bus.busy); end
        run_observe(4'd12, 1, dc, bc, ie, ae);
        tests++; if (dc !== 13) begin fails++; $display("FAIL abort_restart_done got %0d want 13", dc); end
        tests++; if (bus.state_out !== exp) begin fails++; $display("FAIL abort_restart_result got %h want %h", bus.state_out, exp); end
        step();
    endtask

    task automatic test_async_reset();
        int dc, bc, ie, ae;
        logic [319:0] exp;
        exp = perm_n(S5, 6, 6);
        start_perm(S1, 4'd12);
        repeat (7) step();
        tests++; if (round_i !== 4'd7) begin fails++; $display("FAIL arst_pre_round_i got %0d want 7", round_i); end
        #2;
        rst = 1'b1;
        #1;
        tests++; if (bus.busy !== 1'b0 || bus.ready !== 1'b1 || bus.done !== 1'b0) begin fails++; $display("FAIL arst_ctrl got busy=%b ready=%b done=%b want 0/1/0", bus.busy, bus.ready, bus.done); end
        tests++; if (bus.state_out !== 320'd0) begin fails++; $display("FAIL arst_state got %h want 0", bus.state_out); end
        tests++; if (round_i !== 4'd0 || round_a !== 4'd12) begin fails++; $display("FAIL arst_round got i=%0d a=%0d want 0/12", round_i, round_a); end
        step();
        #3;
        rst = 1'b0;
        step();
        start_perm(S5, 4'd6);
        run_observe(4'd6, 1, dc, bc, ie, ae);
        tests++; if (dc !== 7) begin fails++; $display("FAIL arst_fresh_done got %0d want 7", dc); end
        tests++; if (bus.state_out !== exp) begin fails++; $display("FAIL arst_fresh_result got %h want %h", bus.state_out, exp); end
    endtask

    initial begin
        test_reset();
        test_p12_kat();
        test_p6();
        test_invalid_count();
        test_start_during_run();
        test_back_to_back();
        test_abort();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
